// File: rtl/wt_mem_req_arbiter.sv
// rtl/wt_mem_req_arbiter.sv - I$/D$ round-robin request arbiter with per-source outstanding tracking
module wt_mem_req_arbiter #(
  parameter int ReqWidth       = 128,
  parameter int RtrnWidth      = 192,
  parameter int MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 icache_req_i,
  input  logic [ReqWidth-1:0]  icache_data_i,
  output logic                 icache_ack_o,
  input  logic                 dcache_req_i,
  input  logic [ReqWidth-1:0]  dcache_data_i,
  output logic                 dcache_ack_o,
  output logic                 mem_req_o,
  output logic [ReqWidth-1:0]  mem_data_o,
  output logic                 mem_src_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_rtrn_vld_i,
  input  logic                 mem_rtrn_src_i,
  input  logic [RtrnWidth-1:0] mem_rtrn_i,
  output logic                 icache_rtrn_vld_o,
  output logic                 dcache_rtrn_vld_o,
  output logic [RtrnWidth-1:0] rtrn_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_rr_ptr;
  logic            w_rr_ptr_nxt;
  logic [CntW-1:0] r_cnt_i;
  logic [CntW-1:0] r_cnt_d;
  logic            r_err;

  logic w_elig_i;
  logic w_elig_d;
  logic w_req_drop;
  logic w_inc_i;
  logic w_inc_d;
  logic w_dec_i;
  logic w_dec_d;
  logic w_unf_i;
  logic w_unf_d;

  // Cap and stall only gate the decision taken in IDLE; a running grant is never withdrawn.
  assign w_elig_i = icache_req_i & (r_cnt_i < CntMax) & ~stall_i;
  assign w_elig_d = dcache_req_i & (r_cnt_d < CntMax) & ~stall_i;

  // Next-state, grant outputs and acks of the arbitration FSM
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    mem_req_o    = 1'b0;
    mem_src_o    = 1'b0;
    icache_ack_o = 1'b0;
    dcache_ack_o = 1'b0;
    w_req_drop   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_elig_i && w_elig_d) begin
          w_state_nxt = r_rr_ptr ? GNT_D : GNT_I;
        end else if (w_elig_i) begin
          w_state_nxt = GNT_I;
        end else if (w_elig_d) begin
          w_state_nxt = GNT_D;
        end
      end
      GNT_I: begin
        mem_req_o    = 1'b1;
        mem_src_o    = 1'b0;
        icache_ack_o = mem_ack_i;
        w_req_drop   = ~icache_req_i;
        if (mem_ack_i) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = 1'b1;
        end
      end
      GNT_D: begin
        mem_req_o    = 1'b1;
        mem_src_o    = 1'b1;
        dcache_ack_o = mem_ack_i;
        w_req_drop   = ~dcache_req_i;
        if (mem_ack_i) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign mem_data_o = (r_state == GNT_D) ? dcache_data_i : icache_data_i;

  // Returns are steered purely by their tag, with no added latency.
  assign icache_rtrn_vld_o = mem_rtrn_vld_i & ~mem_rtrn_src_i;
  assign dcache_rtrn_vld_o = mem_rtrn_vld_i &  mem_rtrn_src_i;
  assign rtrn_o            = mem_rtrn_i;

  assign w_inc_i = icache_ack_o;
  assign w_inc_d = dcache_ack_o;
  assign w_dec_i = icache_rtrn_vld_o;
  assign w_dec_d = dcache_rtrn_vld_o;

  // A return with nothing outstanding (and no same-cycle ack to cover it) is an underflow.
  assign w_unf_i = w_dec_i & ~w_inc_i & (r_cnt_i == '0);
  assign w_unf_d = w_dec_d & ~w_inc_d & (r_cnt_d == '0);

  // FSM state and round-robin pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Outstanding counters: ack adds one, return removes one, both together cancel
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt_i <= '0;
      r_cnt_d <= '0;
    end else begin
      if (w_inc_i && !w_dec_i) begin
        r_cnt_i <= r_cnt_i + CntOne;
      end else if (!w_inc_i && w_dec_i && (r_cnt_i != '0)) begin
        r_cnt_i <= r_cnt_i - CntOne;
      end
      if (w_inc_d && !w_dec_d) begin
        r_cnt_d <= r_cnt_d + CntOne;
      end else if (!w_inc_d && w_dec_d && (r_cnt_d != '0)) begin
        r_cnt_d <= r_cnt_d - CntOne;
      end
    end
  end

  // Sticky protocol error: request dropped mid-grant or counter underflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_req_drop || w_unf_i || w_unf_d) begin
      r_err <= 1'b1;
    end
  end

  assign busy_o = (r_state != IDLE) | (r_cnt_i != '0) | (r_cnt_d != '0);
  assign err_o  = r_err;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// tb/tb_wt_mem_req_arbiter.sv - self-checking bench for wt_mem_req_arbiter
module tb_wt_mem_req_arbiter;

  localparam int RW   = 128;
  localparam int TW   = 192;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          ireq;
  logic          dreq;
  logic [RW-1:0] idata;
  logic [RW-1:0] ddata;
  logic          mem_ack;
  logic          rvld;
  logic          rsrc;
  logic [TW-1:0] rdata;

  logic          icache_ack_o;
  logic          dcache_ack_o;
  logic          mem_req_o;
  logic [RW-1:0] mem_data_o;
  logic          mem_src_o;
  logic          icache_rtrn_vld_o;
  logic          dcache_rtrn_vld_o;
  logic [TW-1:0] rtrn_o;
  logic          busy_o;
  logic          err_o;

  always #5 clk = ~clk;

  wt_mem_req_arbiter #(
    .ReqWidth      (RW),
    .RtrnWidth     (TW),
    .MaxOutstanding(MAXO)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .stall_i          (stall),
    .icache_req_i     (ireq),
    .icache_data_i    (idata),
    .icache_ack_o     (icache_ack_o),
    .dcache_req_i     (dreq),
    .dcache_data_i    (ddata),
    .dcache_ack_o     (dcache_ack_o),
    .mem_req_o        (mem_req_o),
    .mem_data_o       (mem_data_o),
    .mem_src_o        (mem_src_o),
    .mem_ack_i        (mem_ack),
    .mem_rtrn_vld_i   (rvld),
    .mem_rtrn_src_i   (rsrc),
    .mem_rtrn_i       (rdata),
    .icache_rtrn_vld_o(icache_rtrn_vld_o),
    .dcache_rtrn_vld_o(dcache_rtrn_vld_o),
    .rtrn_o           (rtrn_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  // Reference model: who holds the grant (0 none, 1 I$, 2 D$), who is preferred next,
  // how many requests each cache has in flight, and whether a protocol error was seen.
  int m_g;
  int m_rr;
  int m_cnt[2];
  bit m_err;
  bit m_valid = 1'b0;
  int cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_req();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [TW-1:0] rand_rtrn();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_check();
    chk("mem_req", mem_req_o, m_g != 0);
    if (m_g != 0) begin
      chk("mem_src", mem_src_o, m_g == 2);
      chk("mem_data", mem_data_o, (m_g == 1) ? idata : ddata);
    end
    chk("icache_ack", icache_ack_o, (m_g == 1) && mem_ack);
    chk("dcache_ack", dcache_ack_o, (m_g == 2) && mem_ack);
    chk("icache_rtrn_vld", icache_rtrn_vld_o, rvld && !rsrc);
    chk("dcache_rtrn_vld", dcache_rtrn_vld_o, rvld && rsrc);
    chk("rtrn", rtrn_o, rdata);
    chk("busy", busy_o, (m_g != 0) || (m_cnt[0] != 0) || (m_cnt[1] != 0));
    chk("err", err_o, m_err);
  endtask

  task automatic model_step();
    bit req[2];
    bit elig[2];
    bit inc[2];
    bit dec[2];
    int s;
    if (rst) begin
      m_g = 0; m_rr = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_err = 1'b0;
      return;
    end
    req[0] = ireq; req[1] = dreq;
    inc[0] = 1'b0; inc[1] = 1'b0;
    dec[0] = rvld && !rsrc; dec[1] = rvld && rsrc;
    if (m_g != 0) begin
      s = m_g - 1;
      if (!req[s]) m_err = 1'b1;
      if (mem_ack) begin
        inc[s] = 1'b1;
        m_rr   = 1 - s;
        m_g    = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) elig[k] = req[k] && (m_cnt[k] < MAXO) && !stall;
      if (elig[0] && elig[1]) m_g = m_rr + 1;
      else if (elig[0])       m_g = 1;
      else if (elig[1])       m_g = 2;
    end
    for (int k = 0; k < 2; k++) begin
      if (inc[k] && !dec[k]) m_cnt[k]++;
      else if (dec[k] && !inc[k]) begin
        if (m_cnt[k] == 0) m_err = 1'b1;
        else m_cnt[k]--;
      end
    end
  endtask

  // One clock: compare settled outputs against the model, advance the model, move to next negedge.
  task automatic tick();
    #1;
    if (m_valid) model_check();
    model_step();
    m_valid = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic clr();
    stall = 0; ireq = 0; dreq = 0; mem_ack = 0; rvld = 0; rsrc = 0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1;
    tick();
    rst = 0;
  endtask

  bit pend[2];
  int acked;

  initial begin
    rst = 1; clr();
    idata = rand_req(); ddata = rand_req(); rdata = rand_rtrn();
    tick();
    rst = 0;
    #1;
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    tick();

    // Single I$ request, ack two cycles after mem_req_o, then one return
    do_reset();
    ireq = 1; idata = rand_req();
    #1 chk("t1_req_c0", mem_req_o, 1'b0);
    tick();
    #1 chk("t1_req_c1", mem_req_o, 1'b1);
    chk("t1_src_c1", mem_src_o, 1'b0);
    tick();
    tick();
    mem_ack = 1;
    #1 chk("t1_iack", icache_ack_o, 1'b1);
    tick();
    mem_ack = 0; ireq = 0;
    #1 chk("t1_busy", busy_o, 1'b1);
    chk("t1_model_cnt_i", m_cnt[0], 1);
    tick();
    rvld = 1; rsrc = 0; rdata = rand_rtrn();
    #1 chk("t1_irtrn", icache_rtrn_vld_o, 1'b1);
    chk("t1_drtrn", dcache_rtrn_vld_o, 1'b0);
    tick();
    rvld = 0;
    #1 chk("t1_busy_end", busy_o, 1'b0);
    tick();

    // Both caches requesting with immediate ack: I,D,I,D at one grant per two cycles
    do_reset();
    ireq = 1; dreq = 1; mem_ack = 1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_req", mem_req_o, (k % 2) == 1);
      if ((k % 2) == 1) chk("t2_src", mem_src_o, ((k - 1) / 2) % 2);
      tick();
    end
    chk("t2_model_cnt_i", m_cnt[0], 2);
    chk("t2_model_cnt_d", m_cnt[1], 2);
    clr();

    // D$ fills its cap; the fifth request waits for a return
    do_reset();
    dreq = 1; mem_ack = 1; ddata = rand_req();
    for (int k = 0; k < 8; k++) tick();
    chk("t3_model_cnt_d", m_cnt[1], MAXO);
    for (int k = 0; k < 4; k++) begin
      #1 chk("t3_capped", mem_req_o, 1'b0);
      tick();
    end
    rvld = 1; rsrc = 1; rdata = rand_rtrn();
    #1 chk("t3_rtrn_cycle", mem_req_o, 1'b0);
    tick();
    rvld = 0;
    #1 chk("t3_idle_after_rtrn", mem_req_o, 1'b0);
    tick();
    #1 chk("t3_regrant", mem_req_o, 1'b1);
    chk("t3_dack", dcache_ack_o, 1'b1);
    tick();
    clr();

    // Stall during GNT_D: grant finishes, no new grant until stall drops
    do_reset();
    dreq = 1;
    tick();
    stall = 1;
    #1 chk("t4_gnt_under_stall", mem_req_o, 1'b1);
    chk("t4_src", mem_src_o, 1'b1);
    tick();
    mem_ack = 1;
    #1 chk("t4_dack", dcache_ack_o, 1'b1);
    tick();
    mem_ack = 0;
    for (int k = 0; k < 2; k++) begin
      #1 chk("t4_stalled", mem_req_o, 1'b0);
      tick();
    end
    stall = 0;
    #1 chk("t4_unstall_idle", mem_req_o, 1'b0);
    tick();
    #1 chk("t4_regrant", mem_req_o, 1'b1);
    mem_ack = 1;
    tick();
    clr();

    // Same-cycle ack and return on I$ keep the count; D$ return with nothing outstanding is an error
    do_reset();
    ireq = 1; mem_ack = 1;
    for (int k = 0; k < 5; k++) tick();
    chk("t5_model_cnt_before", m_cnt[0], 2);
    rvld = 1; rsrc = 0; rdata = rand_rtrn();
    tick();
    chk("t5_model_cnt_same", m_cnt[0], 2);
    ireq = 0; mem_ack = 0;
    tick();
    tick();
    rvld = 0;
    #1 chk("t5_busy_drained", busy_o, 1'b0);
    chk("t5_err_clean", err_o, 1'b0);
    tick();
    rvld = 1; rsrc = 1;
    #1 chk("t5_err_before", err_o, 1'b0);
    tick();
    rvld = 0;
    #1 chk("t5_err_set", err_o, 1'b1);
    tick();
    tick();
    #1 chk("t5_err_sticky", err_o, 1'b1);
    tick();

    // Reset in the middle of GNT_I abandons the grant and clears the error
    ireq = 1;
    tick();
    #1 chk("t6_gnt", mem_req_o, 1'b1);
    rst = 1;
    tick();
    rst = 0; dreq = 1;
    #1 chk("t6_req_after_rst", mem_req_o, 1'b0);
    chk("t6_busy_after_rst", busy_o, 1'b0);
    chk("t6_err_after_rst", err_o, 1'b0);
    tick();
    #1 chk("t6_rr_reset", mem_req_o, 1'b1);
    chk("t6_src_i_first", mem_src_o, 1'b0);
    mem_ack = 1;
    tick();
    clr();

    // Randomized traffic against the model
    do_reset();
    pend[0] = 0; pend[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 499) == 0);
      stall = ($urandom_range(0, 4) == 0);
      if (!pend[0] && $urandom_range(0, 2) == 0) begin pend[0] = 1; idata = rand_req(); end
      if (!pend[1] && $urandom_range(0, 2) == 0) begin pend[1] = 1; ddata = rand_req(); end
      ireq = pend[0];
      dreq = pend[1];
      mem_ack = (m_g != 0) && ($urandom_range(0, 1) == 1);
      rdata = rand_rtrn();
      rvld = 0; rsrc = 0;
      if ((m_cnt[0] + m_cnt[1]) > 0 && $urandom_range(0, 2) == 0) begin
        rvld = 1;
        if (m_cnt[0] == 0)      rsrc = 1;
        else if (m_cnt[1] == 0) rsrc = 0;
        else                    rsrc = $urandom_range(0, 1);
      end
      acked = (mem_ack && m_g != 0) ? m_g - 1 : -1;
      tick();
      if (acked >= 0) pend[acked] = 0;
    end
    clr();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wt_mem_req_arbiter.md
Name: wt_mem_req_arbiter

Overview:
Shares one downstream memory-adapter request channel between the I$ and D$ miss/write request channels of the write-through cache subsystem.
- Round-robin arbitration with a grant locked until the downstream ack.
- Tags each forwarded request with its source.
- Counts outstanding transactions per source and enforces a per-source cap.
- Routes returns back to the originating cache by source tag.
- Sits between cva6_icache/wt_dcache and the AXI/L15 adapter.

Parameters:
ReqWidth, 128, width of opaque request payload (packed cache request struct)
RtrnWidth, 192, width of opaque return payload (packed return struct)
MaxOutstanding, 4, max in-flight requests per source (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
stall_i  in  1  block new grants; an in-flight grant completes
icache_req_i  in  1  I$ request valid; held until ack
icache_data_i  in  ReqWidth  I$ payload; stable while req high
icache_ack_o  out  1  single-cycle I$ accept
dcache_req_i  in  1  D$ request valid; held until ack
dcache_data_i  in  ReqWidth  D$ payload
dcache_ack_o  out  1  single-cycle D$ accept
mem_req_o  out  1  downstream request valid
mem_data_o  out  ReqWidth  muxed payload of granted source
mem_src_o  out  1  source tag: 0=I$, 1=D$
mem_ack_i  in  1  downstream single-cycle accept
mem_rtrn_vld_i  in  1  return valid (one cycle per return)
mem_rtrn_src_i  in  1  source tag of the return
mem_rtrn_i  in  RtrnWidth  return payload
icache_rtrn_vld_o  out  1  return valid to I$
dcache_rtrn_vld_o  out  1  return valid to D$
rtrn_o  out  RtrnWidth  return payload, broadcast to both caches
busy_o  out  1  FSM not IDLE or any outstanding count nonzero
err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i high at posedge): FSM=IDLE, rr_ptr=0 (I$ preferred), counters=0, err_o=0. Reset applies mid-grant and abandons the grant; in-flight returns are then not tracked.
- Outputs while IDLE: mem_req_o=0, acks=0, busy_o=0 (when counters also 0).
- Eligibility: src eligible = req_i & (cnt_src < MaxOutstanding) & ~stall_i.
- IDLE: if both eligible, grant rr_ptr's source. Otherwise grant the single eligible source, or stay in IDLE. Next state is GNT_I or GNT_D, registered, so the first mem_req_o is 1 cycle after req_i.
- GNT_x: mem_req_o=1, mem_data_o=x_data_i, mem_src_o=x.
  - On mem_ack_i: x_ack_o=mem_ack_i (combinational, same cycle), cnt_x increments, rr_ptr points to the other source, FSM goes to IDLE.
  - Minimum 1 idle cycle between grants; max throughput 1 request per 2 cycles.
- stall_i and cap apply only in IDLE. They never deassert mem_req_o mid-grant.
- Returns: icache_rtrn_vld_o = mem_rtrn_vld_i & ~mem_rtrn_src_i; dcache_rtrn_vld_o = mem_rtrn_vld_i & mem_rtrn_src_i; rtrn_o = mem_rtrn_i. Zero latency, combinational.
- A return decrements that source's counter.
- Ack and return for the same source in the same cycle: counter unchanged.
- Counter width: $clog2(MaxOutstanding+1).
- Return while the source counter == 0: counter stays 0, err_o set (sticky until reset).
- An ack while the counter == MaxOutstanding cannot occur by construction (the grant was gated).
- busy_o = (state!=IDLE) | (cnt_i!=0) | (cnt_d!=0).
- Source drops req_i before ack: protocol violation; err_o set, grant still completes.

Test Plan:
- Single I$ req, mem_ack_i 2 cycles after mem_req_o -> mem_req_o rises 1 cycle after icache_req_i, mem_src_o=0, icache_ack_o coincides with mem_ack_i, cnt_i=1, busy_o=1; one return with src=0 -> icache_rtrn_vld_o=1, dcache_rtrn_vld_o=0, busy_o=0.
- Both requesting continuously, ack immediate -> grant order I,D,I,D, 1 request per 2 cycles.
- D$ issues 4 requests without returns (MaxOutstanding=4) -> 5th not granted; a src=1 return releases the next grant in the following IDLE cycle.
- stall_i asserted during GNT_D -> grant completes on ack; no new grant until stall_i drops.
- Ack and return both on I$ in the same cycle with cnt_i=2 -> cnt_i stays 2; return with src=1 while cnt_d=0 -> err_o=1 and stays 1.
- rst_i asserted mid-GNT_I -> next cycle mem_req_o=0, busy_o=0, err_o=0, rr_ptr=0.
